// File: rtl/lcd_pkg.sv
// lcd_pkg: shared state encoding, HD44780 command codes and helpers for lcd_ctrl.
//   No ports. Provides lcd_state_e, the power-up init command ROM (init_cmd),
//   the clear/home command codes, the slow-command classifier and an int max helper.
package lcd_pkg;

    typedef enum logic [2:0] {
        S_PWRUP,
        S_INIT,
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_WAIT
    } lcd_state_e;

    localparam logic [7:0] LCD_CMD_CLEAR    = 8'h01;
    localparam logic [7:0] LCD_CMD_HOME     = 8'h02;
    localparam logic [7:0] LCD_CMD_HOME_ALT = 8'h03;

    localparam int         LCD_INIT_LEN     = 4;
    localparam logic [7:0] LCD_INIT_FUNC    = 8'h38;
    localparam logic [7:0] LCD_INIT_DISPLAY = 8'h0C;
    localparam logic [7:0] LCD_INIT_ENTRY   = 8'h06;

    // Init ROM: 8-bit 2-line 5x8, display on, clear, entry mode increment.
    function automatic logic [7:0] init_cmd(input logic [2:0] idx);
        return idx == 3'd0 ? LCD_INIT_FUNC
             : idx == 3'd1 ? LCD_INIT_DISPLAY
             : idx == 3'd2 ? LCD_CMD_CLEAR
             : LCD_INIT_ENTRY;
    endfunction

    // Clear and return-home need the long execution wait; everything else is short.
    function automatic logic is_slow_cmd(input logic rs, input logic [7:0] b);
        return !rs && (b == LCD_CMD_CLEAR || b == LCD_CMD_HOME || b == LCD_CMD_HOME_ALT);
    endfunction

    function automatic int max_int(input int a, input int b);
        return a > b ? a : b;
    endfunction

endpackage

// File: rtl/lcd_timer.sv
// lcd_timer: loadable down-counter that parks at zero.
//   clk    in  clock
//   rst_n  in  asynchronous active-low reset (count <- RESET_VALUE)
//   load   in  load value into the counter this cycle
//   value  in  W-bit load value (cycles remaining minus one)
//   done   out count has reached zero
module lcd_timer #(
    parameter int             W           = 20,
    parameter logic [W-1:0]   RESET_VALUE = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         done
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= RESET_VALUE;
        else if (load)
            count <= value;
        else if (count != '0)
            count <= count - 1'b1;
    end

    assign done = count == '0;

endmodule

// File: rtl/lcd_ctrl.sv
// lcd_ctrl: valid/ready write port driving HD44780 EN/RS/RW/DATA pins with setup, pulse and execution-wait timing.
//   i_clk        in   system clock
//   i_reset      in   asynchronous active-low reset
//   i_req_valid  in   request present
//   o_req_ready  out  request accepted this cycle when high (idle only)
//   i_req_rs     in   0 = command, 1 = data
//   i_req_byte   in   byte to write
//   o_busy       out  transfer or init in progress
//   o_lcd_on     out  LCD power/backlight enable
//   o_lcd_en     out  LCD enable strobe
//   o_lcd_rs     out  LCD register select
//   o_lcd_rw     out  LCD read/write, always write
//   o_lcd_data   out  LCD data bus
// Build option: define LCD_INIT_SEQ_EN to add the power-up delay and the
// automatic 0x38/0x0C/0x01/0x06 init sequence ahead of the first accept.
module lcd_ctrl
    import lcd_pkg::*;
#(
    parameter int T_SETUP_CYC = 2,
    parameter int T_EN_CYC    = 25,
    parameter int T_CMD_CYC   = 2000,
    parameter int T_CLR_CYC   = 82000,
    parameter int T_PWRUP_CYC = 750000
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_req_valid,
    output logic       o_req_ready,
    input  logic       i_req_rs,
    input  logic [7:0] i_req_byte,
    output logic       o_busy,
    output logic       o_lcd_on,
    output logic       o_lcd_en,
    output logic       o_lcd_rs,
    output logic       o_lcd_rw,
    output logic [7:0] o_lcd_data
);

    localparam int T_MAX = max_int(max_int(max_int(T_SETUP_CYC, T_EN_CYC),
                                           max_int(T_CMD_CYC, T_CLR_CYC)), T_PWRUP_CYC);
    localparam int CW    = $clog2(T_MAX + 1);

`ifdef LCD_INIT_SEQ_EN
    localparam lcd_state_e    RESET_STATE = S_PWRUP;
    // The power-up delay runs straight out of reset, so the timer starts preloaded.
    localparam logic [CW-1:0] TIMER_RESET = CW'(T_PWRUP_CYC - 1);
`else
    localparam lcd_state_e    RESET_STATE = S_IDLE;
    localparam logic [CW-1:0] TIMER_RESET = '0;
`endif

    lcd_state_e    state;
    logic          accept;
    logic          load;
    logic          done;
    logic          slow;
    logic          init_pending;
    logic [CW-1:0] value;

`ifdef LCD_INIT_SEQ_EN
    logic [2:0] init_idx;
    assign init_pending = init_idx != 3'(LCD_INIT_LEN);
`else
    assign init_pending = 1'b0;
`endif

    assign accept   = i_req_valid & o_req_ready;
    assign slow     = is_slow_cmd(o_lcd_rs, o_lcd_data);
    assign o_lcd_rw = 1'b0;

    // Setup load is T_SETUP_CYC (not -1): the extra count covers the cycle in
    // which the byte is latched onto the pins, giving accept-to-EN of 1+T_SETUP.
    always_comb begin
        load  = accept || state == S_INIT || (state == S_SETUP && done) || state == S_HOLD;
        value = state == S_SETUP ? CW'(T_EN_CYC - 1)
              : state == S_HOLD  ? (slow ? CW'(T_CLR_CYC - 1) : CW'(T_CMD_CYC - 1))
              : CW'(T_SETUP_CYC);
    end

    lcd_timer #(
        .W           (CW),
        .RESET_VALUE (TIMER_RESET)
    ) u_timer (
        .clk   (i_clk),
        .rst_n (i_reset),
        .load  (load),
        .value (value),
        .done  (done)
    );

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state       <= RESET_STATE;
            o_req_ready <= 1'b0;
            o_busy      <= 1'b0;
            o_lcd_on    <= 1'b0;
            o_lcd_en    <= 1'b0;
            o_lcd_rs    <= 1'b0;
            o_lcd_data  <= '0;
`ifdef LCD_INIT_SEQ_EN
            init_idx    <= '0;
`endif
        end else begin
            o_lcd_on    <= 1'b1;
            o_req_ready <= 1'b0;
            o_busy      <= 1'b1;
            case (state)
`ifdef LCD_INIT_SEQ_EN
                S_PWRUP: if (done) state <= S_INIT;
                S_INIT: begin
                    state      <= S_SETUP;
                    o_lcd_rs   <= 1'b0;
                    o_lcd_data <= init_cmd(init_idx);
                    init_idx   <= init_idx + 3'd1;
                end
`endif
                S_IDLE: begin
                    if (accept) begin
                        state      <= S_SETUP;
                        o_lcd_rs   <= i_req_rs;
                        o_lcd_data <= i_req_byte;
                    end else begin
                        o_req_ready <= 1'b1;
                        o_busy      <= 1'b0;
                    end
                end
                S_SETUP: begin
                    if (done) begin
                        state    <= S_PULSE;
                        o_lcd_en <= 1'b1;
                    end
                end
                S_PULSE: begin
                    if (done) begin
                        state    <= S_HOLD;
                        o_lcd_en <= 1'b0;
                    end
                end
                S_HOLD: state <= S_WAIT;
                S_WAIT: begin
                    if (done) begin
                        state       <= init_pending ? S_INIT : S_IDLE;
                        o_req_ready <= !init_pending;
                        o_busy      <= init_pending;
                    end
                end
                default: state <= RESET_STATE;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_ctrl.sv
// tb_lcd_ctrl: randomized self-checking bench for lcd_ctrl against a timeline model of the write protocol.
module tb_lcd_ctrl;

    localparam int TS   = 2;
    localparam int TE   = 6;
    localparam int TCMD = 40;
    localparam int TCLR = 150;
    localparam int TPWR = 100;
`ifdef LCD_INIT_SEQ_EN
    localparam bit INIT_EN = 1'b1;
`else
    localparam bit INIT_EN = 1'b0;
`endif

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       valid    = 1'b0;
    logic       req_rs   = 1'b0;
    logic [7:0] req_byte = 8'h00;
    logic       ready, busy, lcd_on, en, rs, rw;
    logic [7:0] data;

    int         tests = 0;
    int         fails = 0;
    int         cyc   = 0;
    logic       last_rs   = 1'b0;
    logic [7:0] last_byte = 8'h00;

    lcd_ctrl #(
        .T_SETUP_CYC (TS),
        .T_EN_CYC    (TE),
        .T_CMD_CYC   (TCMD),
        .T_CLR_CYC   (TCLR),
        .T_PWRUP_CYC (TPWR)
    ) dut (
        .i_clk       (clk),
        .i_reset     (rst_n),
        .i_req_valid (valid),
        .o_req_ready (ready),
        .i_req_rs    (req_rs),
        .i_req_byte  (req_byte),
        .o_busy      (busy),
        .o_lcd_on    (lcd_on),
        .o_lcd_en    (en),
        .o_lcd_rs    (rs),
        .o_lcd_rw    (rw),
        .o_lcd_data  (data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int wait_of(input logic r, input logic [7:0] b);
        return (!r && b >= 8'h01 && b <= 8'h03) ? TCLR : TCMD;
    endfunction

    // Performs one write and records when things happened (cycle numbers); no checking here.
    task automatic xfer(input logic r, input logic [7:0] b, output int a, output int rise,
                        output int fall, output int rdy, output logic [9:0] lat, output bit stable);
        int n = 0;
        a = -1; rise = -1; fall = -1; rdy = -1; lat = '1; stable = 1'b1;
        do begin @(negedge clk); n++; end while (!ready && n < 4 * TCLR);
        if (!ready) return;
        valid = 1'b1; req_rs = r; req_byte = b; a = cyc + 1;
        @(negedge clk);
        valid = 1'b0; req_rs = 1'($urandom); req_byte = 8'($urandom);
        lat = {ready, rs, data};
        for (n = 0; n < 4 * TCLR; n++) begin
            if (en && rise < 0) rise = cyc;
            if (!en && rise >= 0 && fall < 0) fall = cyc;
            if ({rs, data} !== {r, b}) stable = 1'b0;
            if (ready) begin rdy = cyc; break; end
            @(negedge clk);
        end
        last_rs = r; last_byte = b;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; valid = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if ({ready, busy, lcd_on, en, rw, rs, data} !== 14'h0) begin
            fails++;
            $display("FAIL reset_outputs: got %h want 0000", {ready, busy, lcd_on, en, rw, rs, data});
        end
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if ({lcd_on, ready, busy, en} !== {1'b1, !INIT_EN, INIT_EN, 1'b0}) begin
            fails++;
            $display("FAIL reset_release on/ready/busy/en: got %b want %b", {lcd_on, ready, busy, en},
                     {1'b1, !INIT_EN, INIT_EN, 1'b0});
        end
        last_rs = 1'b0; last_byte = 8'h00;
    endtask

`ifdef LCD_INIT_SEQ_EN
    task automatic test_init_seq();
        logic [7:0] init_exp [4];
        logic [8:0] seen [$];
        int         rises [$];
        int         falls [$];
        logic       prev_en = 1'b0;
        int         r = -1;
        int         urise = -1;
        logic [8:0] udata = '1;
        init_exp = '{8'h38, 8'h0C, 8'h01, 8'h06};
        for (int n = 0; n < TPWR + 4 * (TCLR + TS + TE + 5) + 50; n++) begin
            valid = 1'b1; req_rs = 1'($urandom); req_byte = 8'($urandom);
            @(negedge clk);
            if (en && !prev_en) begin rises.push_back(cyc); seen.push_back({rs, data}); end
            if (!en && prev_en) falls.push_back(cyc);
            prev_en = en;
            if (ready) begin r = cyc; break; end
        end
        req_rs = 1'b1; req_byte = 8'hA5;
        @(negedge clk);
        valid = 1'b0;
        for (int n = 0; n < 4 * TCLR && urise < 0; n++) begin
            if (en) begin urise = cyc; udata = {rs, data}; end
            else @(negedge clk);
        end
        tests++;
        if (rises.size() !== 4 || falls.size() !== 4) begin
            fails++;
            $display("FAIL init_pulse_count: got %0d rises %0d falls want 4", rises.size(), falls.size());
        end
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (((i < seen.size()) ? seen[i] : 9'h1FF) !== {1'b0, init_exp[i]}) begin
                fails++;
                $display("FAIL init_cmd[%0d]: got %h want %h", i, (i < seen.size()) ? seen[i] : 9'h1FF,
                         {1'b0, init_exp[i]});
            end
            tests++;
            if (i >= falls.size() || falls[i] - rises[i] !== TE) begin
                fails++;
                $display("FAIL init_width[%0d]: got %0d want %0d", i,
                         (i < falls.size()) ? falls[i] - rises[i] : -1, TE);
            end
        end
        tests++;
        if (rises.size() < 4 || falls.size() < 3 || rises[3] - falls[2] < 2 + TCLR + TS) begin
            fails++;
            $display("FAIL init_clear_wait: got %0d want >= %0d",
                     (rises.size() >= 4 && falls.size() >= 3) ? rises[3] - falls[2] : -1, 2 + TCLR + TS);
        end
        tests++;
        if (falls.size() < 4 || r !== falls[3] + 1 + TCMD) begin
            fails++;
            $display("FAIL init_ready_time: got %0d want %0d", r, (falls.size() >= 4) ? falls[3] + 1 + TCMD : -1);
        end
        tests++;
        if (urise !== r + 2 + TS || udata !== 9'h1A5) begin
            fails++;
            $display("FAIL init_first_user: rise %0d data %h want rise %0d data 1a5", urise, udata, r + 2 + TS);
        end
        last_rs = 1'b1; last_byte = 8'hA5;
    endtask
`endif

    task automatic test_single_write();
        int a, rise, fall, rdy;
        logic [9:0] lat;
        bit stable;
        xfer(1'b1, 8'h41, a, rise, fall, rdy, lat, stable);
        tests++;
        if (lat !== {1'b0, 1'b1, 8'h41}) begin
            fails++; $display("FAIL write_latch ready/rs/data: got %h want 141", lat);
        end
        tests++;
        if (rise !== a + 1 + TS) begin
            fails++; $display("FAIL write_en_rise: got %0d want %0d", rise, a + 1 + TS);
        end
        tests++;
        if (fall - rise !== TE) begin
            fails++; $display("FAIL write_en_width: got %0d want %0d", fall - rise, TE);
        end
        tests++;
        if (rdy !== a + TS + TE + 2 + TCMD) begin
            fails++; $display("FAIL write_ready_back: got %0d want %0d", rdy, a + TS + TE + 2 + TCMD);
        end
        tests++;
        if (!stable) begin
            fails++; $display("FAIL write_rs_data_stable: got 0 want 1");
        end
    endtask

    task automatic test_wait_times();
        logic [8:0] tbl [8];
        int a, rise, fall, rdy;
        logic [9:0] lat;
        bit stable;
        tbl = '{9'h001, 9'h002, 9'h003, 9'h080, 9'h101, 9'h000, 9'h004, {1'b0, 8'($urandom)}};
        for (int i = 0; i < 8; i++) begin
            xfer(tbl[i][8], tbl[i][7:0], a, rise, fall, rdy, lat, stable);
            tests++;
            if (rdy - a !== TS + TE + 2 + wait_of(tbl[i][8], tbl[i][7:0])) begin
                fails++;
                $display("FAIL wait_latency rs=%b byte=%h: got %0d want %0d", tbl[i][8], tbl[i][7:0],
                         rdy - a, TS + TE + 2 + wait_of(tbl[i][8], tbl[i][7:0]));
            end
            tests++;
            if ({rise - a, fall - rise} !== {1 + TS, TE} || !stable) begin
                fails++;
                $display("FAIL wait_pulse byte=%h: setup %0d width %0d stable %b want %0d %0d 1",
                         tbl[i][7:0], rise - a, fall - rise, stable, 1 + TS, TE);
            end
        end
    endtask

    // Cycle-by-cycle comparison against a timeline model: pct = chance valid is offered each cycle.
    task automatic test_stream(input int pct, input int n_acc);
        int         acc_t = -100000;
        int         rdy_t;
        int         got = 0;
        int         errs = 0;
        int         t;
        int         bound;
        int         n = 0;
        logic       m_rs;
        logic [7:0] m_byte;
        logic [13:0] exp_v, obs;
        do begin @(negedge clk); n++; end while (!ready && n < 4 * TCLR);
        rdy_t = cyc; m_rs = last_rs; m_byte = last_byte;
        bound = cyc + n_acc * (TS + TE + 3 + TCLR) + 400;
        while ((got < n_acc || cyc <= rdy_t) && cyc < bound) begin
            t = cyc;
            exp_v = {t >= rdy_t, t < rdy_t, 1'b1, (t >= acc_t + 1 + TS) && (t < acc_t + 1 + TS + TE),
                     1'b0, m_rs, m_byte};
            obs = {ready, busy, lcd_on, en, rw, rs, data};
            tests++;
            if (obs !== exp_v) begin
                fails++; errs++;
                $display("FAIL stream%0d cyc=%0d rdy/busy/on/en/rw/rs/data: got %h want %h", pct, t, obs, exp_v);
                if (errs >= 8) break;
            end
            valid    = got < n_acc && $urandom_range(99) < pct;
            req_rs   = 1'($urandom);
            req_byte = ($urandom_range(3) == 0) ? 8'($urandom_range(4)) : 8'($urandom);
            if (valid && t >= rdy_t) begin
                acc_t  = t + 1;
                m_rs   = req_rs;
                m_byte = req_byte;
                rdy_t  = acc_t + TS + TE + 2 + wait_of(req_rs, req_byte);
                got++;
            end
            @(negedge clk);
        end
        valid = 1'b0;
        last_rs = m_rs; last_byte = m_byte;
        tests++;
        if (got !== n_acc) begin
            fails++; $display("FAIL stream%0d_accepts: got %0d want %0d", pct, got, n_acc);
        end
    endtask

    task automatic test_reset_in_pulse();
        int   n = 0;
        bit   stale = 1'b0;
        logic was_en;
        logic first_ready;
        do begin @(negedge clk); n++; end while (!ready && n < 4 * TCLR);
        valid = 1'b1; req_rs = 1'b1; req_byte = 8'h5A;
        @(negedge clk);
        valid = 1'b0;
        for (n = 0; n < 50 && !en; n++) @(negedge clk);
        @(negedge clk);
        was_en = en;
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (!was_en || {ready, busy, lcd_on, en, rw, rs, data} !== 14'h0) begin
            fails++;
            $display("FAIL reset_in_pulse: en_before %b outputs %h want 1 and 0000", was_en,
                     {ready, busy, lcd_on, en, rw, rs, data});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        first_ready = ready;
        for (n = 0; n < (INIT_EN ? TPWR - 2 : TS + TE + 20); n++) begin
            if (en || rs || data !== 8'h00 || !lcd_on) stale = 1'b1;
            @(negedge clk);
        end
        tests++;
        if (first_ready !== !INIT_EN) begin
            fails++; $display("FAIL reset_in_pulse_ready: got %b want %b", first_ready, !INIT_EN);
        end
        tests++;
        if (stale) begin
            fails++; $display("FAIL reset_in_pulse_stale_pulse: got 1 want 0");
        end
    endtask

    initial begin
        test_reset();
`ifdef LCD_INIT_SEQ_EN
        test_init_seq();
`endif
        test_single_write();
        test_wait_times();
        test_stream(100, 8);
        test_stream(40, 8);
        test_reset_in_pulse();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
